pipeline_stage_skid: RTL

PIPELINE_STAGE_SKID -- requirements
Module: pipeline_stage_skid

---
 rtl/pipeline_stage_skid.sv | 117 +++++++++++
 1 files changed

// File: rtl/pipeline_stage_skid.sv
// Two-entry skid-buffered pipeline register with fully registered in_ready.
// Optional perf counters (stall_cnt, bubble_cnt) under `PIPELINE_STAGE_PERF_EN.
module pipeline_stage_skid #(
  parameter int unsigned       DATA_W      = 64,
  parameter logic [DATA_W-1:0] RESET_VALUE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPELINE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (in_xfer) state_d = ONE;
        ONE:     if (in_xfer && !out_xfer) state_d = TWO;
                 else if (!in_xfer && out_xfer) state_d = EMPTY;
        TWO:     if (out_xfer) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Both handshake outputs decode only the state register, so out_ready
  // never reaches in_ready combinationally.
  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
    out_data  = main_q;
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = RESET_VALUE;
      skid_d = RESET_VALUE;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) main_d = in_data;
        ONE: begin
          if (in_xfer && out_xfer)  main_d = in_data;
          else if (in_xfer)         skid_d = in_data;
          else if (out_xfer)        main_d = RESET_VALUE;
        end
        TWO: if (out_xfer) begin
          main_d = skid_q;
          skid_d = RESET_VALUE;
        end
        default: begin
          main_d = RESET_VALUE;
          skid_d = RESET_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

`ifdef PIPELINE_STAGE_PERF_EN
  logic [31:0] stall_q, bubble_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (!out_valid && (bubble_q != 32'hFFFF_FFFF))             bubble_q <= bubble_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  // Counters absent in this build.
`endif

endmodule
